// File: rtl/but_pkg.sv
// Shared constants for the complex butterfly pipeline: counter width and
// the encoding of the per-beat scale control.
package but_pkg;

  localparam int unsigned SAT_CNT_W = 16;

  typedef enum logic {
    SCL_NONE = 1'b0,
    SCL_HALF = 1'b1
  } scl_e;

endpackage

// File: rtl/but_sat.sv
// Signed saturating narrower: clamps an IN_W-bit value into OUT_W bits and
// reports whether clamping happened.
module but_sat #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clamp
);

  logic fits;

  always_comb begin
    // Value fits when every bit from the output sign position upward matches the sign.
    fits  = (din[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){din[IN_W-1]}});
    clamp = !fits;
    if (fits)
      dout = din[OUT_W-1:0];
    else if (din[IN_W-1])
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    else
      dout = {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/but_cplx_pipe.sv
// Two-stage complex butterfly (a+b, a-b) with optional halving, output
// saturation, valid/ready flow control and sticky saturation statistics.
module but_cplx_pipe
  import but_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_W-1:0]      in_a_r,
  input  logic signed [IN_W-1:0]      in_a_i,
  input  logic signed [IN_W-1:0]      in_b_r,
  input  logic signed [IN_W-1:0]      in_b_i,
  input  logic                        in_scl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_W-1:0]     out_p_r,
  output logic signed [OUT_W-1:0]     out_p_i,
  output logic signed [OUT_W-1:0]     out_n_r,
  output logic signed [OUT_W-1:0]     out_n_i,
  output logic                        ovf,
  input  logic                        ovf_clr,
  output logic [SAT_CNT_W-1:0]        sat_cnt
);

  localparam int unsigned SW = IN_W + 1;

  logic                 s1_full;
  logic signed [SW-1:0] s1_pr, s1_pi, s1_nr, s1_ni;
  scl_e                 s1_scl;

  logic signed [SW-1:0] sum_r, sum_i, dif_r, dif_i;
  logic signed [SW-1:0] sh_pr, sh_pi, sh_nr, sh_ni;
  logic signed [OUT_W-1:0] st_pr, st_pi, st_nr, st_ni;
  logic [3:0]           clamp;
  logic                 s2_sat;
  logic                 s2_adv;
  logic                 deliver;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_full || s2_adv;
  assign deliver  = out_valid && out_ready;

  always_comb begin
    sum_r = {in_a_r[IN_W-1], in_a_r} + {in_b_r[IN_W-1], in_b_r};
    sum_i = {in_a_i[IN_W-1], in_a_i} + {in_b_i[IN_W-1], in_b_i};
    dif_r = {in_a_r[IN_W-1], in_a_r} - {in_b_r[IN_W-1], in_b_r};
    dif_i = {in_a_i[IN_W-1], in_a_i} - {in_b_i[IN_W-1], in_b_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full <= 1'b0;
      s1_pr   <= '0;
      s1_pi   <= '0;
      s1_nr   <= '0;
      s1_ni   <= '0;
      s1_scl  <= SCL_NONE;
    end else if (in_ready) begin
      s1_full <= in_valid;
      if (in_valid) begin
        s1_pr  <= sum_r;
        s1_pi  <= sum_i;
        s1_nr  <= dif_r;
        s1_ni  <= dif_i;
        s1_scl <= scl_e'(in_scl);
      end
    end
  end

  always_comb begin
    sh_pr = (s1_scl == SCL_HALF) ? (s1_pr >>> 1) : s1_pr;
    sh_pi = (s1_scl == SCL_HALF) ? (s1_pi >>> 1) : s1_pi;
    sh_nr = (s1_scl == SCL_HALF) ? (s1_nr >>> 1) : s1_nr;
    sh_ni = (s1_scl == SCL_HALF) ? (s1_ni >>> 1) : s1_ni;
  end

  but_sat #(.IN_W(SW), .OUT_W(OUT_W)) u_sat_pr (.din(sh_pr), .dout(st_pr), .clamp(clamp[0]));
  but_sat #(.IN_W(SW), .OUT_W(OUT_W)) u_sat_pi (.din(sh_pi), .dout(st_pi), .clamp(clamp[1]));
  but_sat #(.IN_W(SW), .OUT_W(OUT_W)) u_sat_nr (.din(sh_nr), .dout(st_nr), .clamp(clamp[2]));
  but_sat #(.IN_W(SW), .OUT_W(OUT_W)) u_sat_ni (.din(sh_ni), .dout(st_ni), .clamp(clamp[3]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p_r   <= '0;
      out_p_i   <= '0;
      out_n_r   <= '0;
      out_n_i   <= '0;
      s2_sat    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_full;
      if (s1_full) begin
        out_p_r <= st_pr;
        out_p_i <= st_pi;
        out_n_r <= st_nr;
        out_n_i <= st_ni;
        s2_sat  <= |clamp;
      end
    end
  end

  // A saturated delivery outranks a coincident clear: ovf ends at 1, count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf     <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (deliver && s2_sat)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;

      if (ovf_clr)
        sat_cnt <= (deliver && s2_sat) ? SAT_CNT_W'(1) : '0;
      else if (deliver && s2_sat && (sat_cnt != '1))
        sat_cnt <= sat_cnt + SAT_CNT_W'(1);
    end
  end

endmodule
